// File: rtl/tone_arbiter.sv
// Tone arbiter: owns the single note/octave/LED/segment output path shared by the
// free-play, auto-play and learn sources. A one-hot mode switch selects the source;
// every mode change inserts a muted gap, and note/octave changes are rate-limited
// so the tone generator never sees glitches or notes shorter than the hold time.
module tone_arbiter #(
  parameter int unsigned GAP_CYCLES = 100000,
  parameter int unsigned MIN_HOLD   = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic [3:0] free_note,
  input  logic [1:0] free_oct,
  input  logic [6:0] free_led,
  input  logic [3:0] auto_note,
  input  logic [1:0] auto_oct,
  input  logic [6:0] auto_led,
  input  logic [3:0] learn_note,
  input  logic [1:0] learn_oct,
  input  logic [6:0] learn_led,
  input  logic [3:0] learn_num,
  output logic [3:0] note_out,
  output logic [1:0] octave_out,
  output logic [6:0] led_out,
  output logic [3:0] num_out,
  output logic [2:0] grant,
  output logic       busy
);

  // Counter widths: $clog2 of the parameter, never narrower than one bit.
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

  localparam logic [GW-1:0] GAP_INIT  = GW'(GAP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_HOLD - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SWITCH = 2'd1;
  localparam logic [1:0] GRANT  = 2'd2;

  localparam logic [2:0] MODE_FREE  = 3'b100;
  localparam logic [2:0] MODE_AUTO  = 3'b010;
  localparam logic [2:0] MODE_LEARN = 3'b001;

  logic [2:0]    mode_q;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    note_q, note_d;
  logic [1:0]    oct_q, oct_d;
  logic [6:0]    led_q, led_d;
  logic [3:0]    num_q, num_d;
  logic [2:0]    grant_q, grant_d;
  logic          busy_q, busy_d;

  logic [3:0] src_note;
  logic [1:0] src_oct;
  logic [6:0] src_led;
  logic [3:0] src_num;
  logic       mode_change;
  logic       mode_valid;

  assign mode_change = (mode != mode_q);
  assign mode_valid  = (mode == MODE_FREE) || (mode == MODE_AUTO) || (mode == MODE_LEARN);

  // Source mux keyed on the registered mode; only used when no change is pending,
  // so mode_q equals the live mode whenever it matters.
  always_comb begin
    src_note = 4'd0;
    src_oct  = 2'd0;
    src_led  = 7'd0;
    src_num  = 4'd0;
    case (mode_q)
      MODE_FREE: begin
        src_note = free_note;
        src_oct  = free_oct;
        src_led  = free_led;
      end
      MODE_AUTO: begin
        src_note = auto_note;
        src_oct  = auto_oct;
        src_led  = auto_led;
      end
      MODE_LEARN: begin
        src_note = learn_note;
        src_oct  = learn_oct;
        src_led  = learn_led;
        src_num  = learn_num;
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic; a mode change overrides every state.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    note_d  = 4'd0;
    oct_d   = 2'd0;
    led_d   = 7'd0;
    num_d   = 4'd0;
    grant_d = 3'b000;
    busy_d  = 1'b0;

    if (mode_change) begin
      hold_d = '0;
      if (mode_valid) begin
        state_d = SWITCH;
        gap_d   = GAP_INIT;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        gap_d   = '0;
      end
    end else begin
      case (state_q)
        SWITCH: begin
          if (gap_q == '0) begin
            state_d = GRANT;
            note_d  = src_note;
            oct_d   = src_oct;
            led_d   = src_led;
            num_d   = src_num;
            grant_d = mode_q;
            hold_d  = HOLD_INIT;
          end else begin
            gap_d  = gap_q - GW'(1);
            busy_d = 1'b1;
          end
        end
        GRANT: begin
          grant_d = mode_q;
          led_d   = src_led;
          num_d   = src_num;
          note_d  = note_q;
          oct_d   = oct_q;
          // Note and octave move only as a pair, at most once per hold window;
          // values that come and go during the window are simply dropped.
          if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
          end else if ({src_note, src_oct} != {note_q, oct_q}) begin
            note_d = src_note;
            oct_d  = src_oct;
            hold_d = HOLD_INIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset clears outputs asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= 3'b000;
      state_q <= IDLE;
      gap_q   <= '0;
      hold_q  <= '0;
      note_q  <= 4'd0;
      oct_q   <= 2'd0;
      led_q   <= 7'd0;
      num_q   <= 4'd0;
      grant_q <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      mode_q  <= mode;
      state_q <= state_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      note_q  <= note_d;
      oct_q   <= oct_d;
      led_q   <= led_d;
      num_q   <= num_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign note_out   = note_q;
  assign octave_out = oct_q;
  assign led_out    = led_q;
  assign num_out    = num_q;
  assign grant      = grant_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with GAP_CYCLES=4, MIN_HOLD=3.
module tb_tone_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] mode;
  logic [3:0] free_note, auto_note, learn_note, learn_num;
  logic [1:0] free_oct, auto_oct, learn_oct;
  logic [6:0] free_led, auto_led, learn_led;
  logic [3:0] note_out;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic [3:0] num_out;
  logic [2:0] grant;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  tone_arbiter #(
    .GAP_CYCLES(4),
    .MIN_HOLD  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .free_note (free_note),
    .free_oct  (free_oct),
    .free_led  (free_led),
    .auto_note (auto_note),
    .auto_oct  (auto_oct),
    .auto_led  (auto_led),
    .learn_note(learn_note),
    .learn_oct (learn_oct),
    .learn_led (learn_led),
    .learn_num (learn_num),
    .note_out  (note_out),
    .octave_out(octave_out),
    .led_out   (led_out),
    .num_out   (num_out),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every output at once: {note, oct, led, num, grant, busy}.
  task automatic expect_out(input string tag, input logic [3:0] e_note, input logic [1:0] e_oct,
                            input logic [6:0] e_led, input logic [3:0] e_num,
                            input logic [2:0] e_grant, input logic e_busy);
    logic [20:0] obs;
    logic [20:0] exp;
    obs = {note_out, octave_out, led_out, num_out, grant, busy};
    exp = {e_note, e_oct, e_led, e_num, e_grant, e_busy};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (note,oct,led,num,grant,busy)", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    mode = 3'b000;
    free_note = 4'd0; free_oct = 2'd0; free_led = 7'd0;
    auto_note = 4'd0; auto_oct = 2'd0; auto_led = 7'd0;
    learn_note = 4'd0; learn_oct = 2'd0; learn_led = 7'd0; learn_num = 4'd0;

    // Reset state, before and after clock edges.
    #3;
    expect_out("reset_t0", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b0);
    step();
    step();
    expect_out("reset_held", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b0);

    // 1. Power-up into free mode: 4-cycle muted gap, then grant.
    mode = 3'b100; free_note = 4'd5; free_oct = 2'd1; free_led = 7'h11;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("pwr_gap", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b1);
    end
    step();
    expect_out("pwr_grant", 4'd5, 2'd1, 7'h11, 4'd0, 3'b100, 1'b0);

    // 2. Free -> auto: mute at the next edge, gap, then auto source.
    mode = 3'b010; auto_note = 4'd9; auto_oct = 2'd2; auto_led = 7'h41;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("f2a_gap", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b1);
    end
    step();
    expect_out("f2a_grant", 4'd9, 2'd2, 7'h41, 4'd0, 3'b010, 1'b0);

    // 4. Invalid mode -> IDLE, then learn mode with its digit.
    mode = 3'b011;
    step();
    expect_out("idle_enter", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b0);
    step();
    expect_out("idle_stay", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b0);
    mode = 3'b001; learn_num = 4'd6; learn_note = 4'd4; learn_oct = 2'd3; learn_led = 7'h22;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("learn_gap", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b1);
    end
    step();
    expect_out("learn_grant", 4'd4, 2'd3, 7'h22, 4'd6, 3'b001, 1'b0);
    // LED and digit are not held: they track the source on the next edge.
    learn_num = 4'd8; learn_led = 7'h15;
    step();
    expect_out("learn_follow", 4'd4, 2'd3, 7'h15, 4'd8, 3'b001, 1'b0);

    // Back to free mode, then let the hold window expire.
    mode = 3'b100;
    for (int i = 0; i < 4; i++) step();
    expect_out("free_gap_end", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b1);
    step();
    expect_out("free_grant", 4'd5, 2'd1, 7'h11, 4'd0, 3'b100, 1'b0);
    step();
    step();
    step();

    // 3. Hold rule: 3 is held 3 cycles, 7 is dropped, 2 is taken.
    free_note = 4'd3;
    step();
    expect_out("hold_3a", 4'd3, 2'd1, 7'h11, 4'd0, 3'b100, 1'b0);
    free_note = 4'd7;
    step();
    expect_out("hold_3b", 4'd3, 2'd1, 7'h11, 4'd0, 3'b100, 1'b0);
    free_note = 4'd2;
    step();
    expect_out("hold_3c", 4'd3, 2'd1, 7'h11, 4'd0, 3'b100, 1'b0);
    step();
    expect_out("hold_take2", 4'd2, 2'd1, 7'h11, 4'd0, 3'b100, 1'b0);
    // Rest obeys the same hold: 2 stays frozen for its window.
    free_note = 4'd0;
    step();
    expect_out("hold_rest_frozen", 4'd2, 2'd1, 7'h11, 4'd0, 3'b100, 1'b0);

    // 5. 100 -> 010, then 001 two cycles into the gap: 6 busy cycles total.
    learn_note = 4'd9; learn_oct = 2'd0; learn_led = 7'h7f; learn_num = 4'd6;
    mode = 3'b010;
    step();
    expect_out("restart_gap1", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b1);
    step();
    expect_out("restart_gap2", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b1);
    mode = 3'b001;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("restart_gap_tail", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b1);
    end
    step();
    expect_out("restart_grant", 4'd9, 2'd0, 7'h7f, 4'd6, 3'b001, 1'b0);

    // 6. Reset between edges clears outputs at once; full gap after release.
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_reset", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("post_reset_gap", 4'd0, 2'd0, 7'h00, 4'd0, 3'b000, 1'b1);
    end
    step();
    expect_out("post_reset_grant", 4'd9, 2'd0, 7'h7f, 4'd6, 3'b001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
